// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch FSM states, fault codes and instruction field positions
package mips_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} fetch_state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: instruction memory request/ready bus
interface mips_fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (output mem_req, mem_addr, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ready);

endinterface

// File: rtl/mips_ir_decode.sv
// mips_ir_decode: splits the instruction register into its encoding fields
module mips_ir_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm
);

    assign op    = ir[OP_LSB +: 6];
    assign funct = ir[FUNCT_LSB +: 6];
    assign rs    = ir[RS_LSB +: 5];
    assign rt    = ir[RT_LSB +: 5];
    assign rd    = ir[RD_LSB +: 5];
    assign imm   = ir[IMM_LSB +: 16];

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC/IR owner running the instruction fetch handshake
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          TW       = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_start,
    input  logic               pcen,
    input  logic [31:0]        pcnext,
    input  logic               fault_clr,
    mips_fetch_unit_if.master  imem,
    output logic               instr_valid,
    output logic               busy,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [31:0]        pc,
    output logic [31:0]        pcplus4,
    output logic [31:0]        ir,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [15:0]        imm
);

    fetch_state_t  state, nxt;
    logic [31:0]   fetch_addr;
    logic [TW-1:0] cnt;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // next state: a ready on the final wait cycle beats the timeout
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (fetch_start) nxt = (pc[1:0] == 2'b00) ? REQ : FAULT;
            REQ:   nxt = imem.mem_ready ? DONE : (cnt == TW'(TIMEOUT - 1)) ? FAULT : REQ;
            DONE:  nxt = IDLE;
            FAULT: if (fault_clr) nxt = IDLE;
        endcase
    end

    // pc, latched fetch address, wait counter, ir and sticky fault code
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            fetch_addr <= '0;
            cnt        <= '0;
            ir         <= '0;
            fault_code <= FC_NONE;
        end else begin
            if (pcen) pc <= pcnext;
            if (state == IDLE && nxt == REQ) fetch_addr <= pc;
            cnt <= (state == REQ && nxt == REQ) ? cnt + TW'(1) : '0;
            if (state == REQ && imem.mem_ready) ir <= imem.mem_rdata;
            if (state != FAULT && nxt == FAULT) fault_code <= (state == IDLE) ? FC_MISALIGN : FC_TIMEOUT;
            else if (state == FAULT && nxt == IDLE) fault_code <= FC_NONE;
        end
    end

    assign imem.mem_req  = (state == REQ);
    assign imem.mem_addr = fetch_addr;
    assign instr_valid   = (state == DONE);
    assign busy          = (state == REQ) || (state == DONE);
    assign fault         = (state == FAULT);
    assign pcplus4       = pc + 32'd4;

    mips_ir_decode u_dec (
        .ir    (ir),
        .op    (op),
        .funct (funct),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .imm   (imm)
    );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed fetch scenarios checked against a behavioural model
module tb_mips_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 0, reset = 1, fetch_start = 0, pcen = 0, fault_clr = 0;
    logic [31:0] pcnext = 0;
    logic        instr_valid, busy, fault;
    logic [1:0]  fault_code;
    logic [31:0] pc, pcplus4, ir;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int          vectors = 0, miscompares = 0, req_total = 0;

    bit          m_wait = 0, m_pulse = 0;
    int          m_waited = 0;
    logic [1:0]  m_fc = 0;
    logic [31:0] m_pc = RESET_PC, m_ir = 0, m_addr = 0;

    mips_fetch_unit_if imem ();

    mips_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .TW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pcen        (pcen),
        .pcnext      (pcnext),
        .fault_clr   (fault_clr),
        .imem        (imem),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fault       (fault),
        .fault_code  (fault_code),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .ir          (ir),
        .op          (op),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm         (imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: outstanding request, cycles waited, pending pulse, fault code
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wait <= 0; m_pulse <= 0; m_waited <= 0; m_fc <= 0;
            m_pc <= RESET_PC; m_ir <= 0; m_addr <= 0;
        end else begin
            if (m_pulse) m_pulse <= 0;
            else if (m_wait) begin
                if (imem.mem_ready) begin
                    m_ir <= imem.mem_rdata; m_wait <= 0; m_pulse <= 1;
                end else if (m_waited + 1 == TIMEOUT) begin
                    m_wait <= 0; m_fc <= 2;
                end else m_waited <= m_waited + 1;
            end else if (m_fc != 0) begin
                if (fault_clr) m_fc <= 0;
            end else if (fetch_start) begin
                if (m_pc % 4 != 0) m_fc <= 1;
                else begin
                    m_wait <= 1; m_waited <= 0; m_addr <= m_pc;
                end
            end
            if (pcen) m_pc <= pcnext;
        end
    end

    // compare every cycle outside reset
    always @(negedge clk) begin
        if (reset) begin
            chk("mem_req", imem.mem_req, m_wait);
            if (m_wait) chk("mem_addr", imem.mem_addr, m_addr);
            chk("instr_valid", instr_valid, m_pulse);
            chk("busy", busy, m_wait | m_pulse);
            chk("fault", fault, m_fc != 0);
            chk("fault_code", fault_code, m_fc);
            chk("pc", pc, m_pc);
            chk("pcplus4", pcplus4, m_pc + 32'd4);
            chk("ir", ir, m_ir);
            chk("op", op, m_ir >> 26);
            chk("funct", funct, m_ir % 64);
            chk("rs", rs, (m_ir >> 21) % 32);
            chk("rt", rt, (m_ir >> 16) % 32);
            chk("rd", rd, (m_ir >> 11) % 32);
            chk("imm", imm, m_ir % 65536);
        end
    end

    always @(negedge clk) if (imem.mem_req === 1'b1) req_total <= req_total + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start a fetch, raise ready in wait cycle lat, return cycles until instr_valid
    task automatic fetch(input int lat, input logic [31:0] data, output int n);
        fetch_start = 1;
        imem.mem_rdata = data;
        imem.mem_ready = (lat == 1);
        tick;
        fetch_start = 0;
        n = 1;
        while (instr_valid !== 1'b1 && n < 40) begin
            imem.mem_ready = (n == lat);
            tick;
            n++;
        end
        imem.mem_ready = 0;
    endtask

    initial begin
        int n, base;
        imem.mem_ready = 0;
        imem.mem_rdata = 0;
        #1 reset = 0;
        #1;
        chk("rst_mem_req", imem.mem_req, 0);
        chk("rst_mem_addr", imem.mem_addr, 0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_ir", ir, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_code", fault_code, 0);
        tick; tick;
        reset = 1;
        tick;

        base = req_total;
        fetch(1, 32'h2002_0005, n);
        chk("t1_latency", n, 2);
        chk("t1_op", op, 6'b001000);
        chk("t1_rt", rt, 2);
        chk("t1_imm", imm, 5);
        chk("t1_addr", imem.mem_addr, 0);
        tick;
        chk("t1_req_cycles", req_total - base, 1);

        base = req_total;
        fetch(3, 32'h0085_3020, n);
        chk("t2_latency", n, 4);
        chk("t2_op", op, 0);
        chk("t2_funct", funct, 6'b100000);
        chk("t2_rs", rs, 4);
        chk("t2_rt", rt, 5);
        chk("t2_rd", rd, 6);
        tick;
        chk("t2_req_cycles", req_total - base, 3);

        pcen = 1; pcnext = 32'h6;
        tick;
        pcen = 0;
        base = req_total;
        fetch_start = 1;
        tick;
        fetch_start = 0;
        chk("t3_fault", fault, 1);
        chk("t3_code", fault_code, 2'b01);
        fetch_start = 1;
        tick;
        fetch_start = 0;
        chk("t3_fault_held", fault, 1);
        chk("t3_no_req", req_total - base, 0);
        fault_clr = 1;
        tick;
        fault_clr = 0;
        chk("t3_cleared", fault, 0);
        chk("t3_code_clr", fault_code, 2'b00);
        pcen = 1; pcnext = 32'h0;
        tick;
        pcen = 0;

        base = req_total;
        fetch_start = 1;
        tick;
        fetch_start = 0;
        n = 0;
        while (fault !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("t4_timeout_cycles", n, 16);
        chk("t4_req_cycles", req_total - base, 16);
        chk("t4_code", fault_code, 2'b10);
        fault_clr = 1;
        tick;
        fault_clr = 0;
        fetch(16, 32'hAC43_0004, n);
        chk("t4_late_latency", n, 17);
        chk("t4_late_nofault", fault, 0);
        chk("t4_late_ir", ir, 32'hAC43_0004);
        tick;

        fetch_start = 1;
        tick;
        fetch_start = 0;
        pcen = 1; pcnext = 32'h40;
        tick;
        pcen = 0;
        chk("t5_addr_held", imem.mem_addr, 0);
        chk("t5_pc", pc, 32'h40);
        chk("t5_pcplus4", pcplus4, 32'h44);
        imem.mem_ready = 1; imem.mem_rdata = 32'h8C22_0008;
        tick;
        imem.mem_ready = 0;
        tick;
        pcen = 1; pcnext = 32'hFFFF_FFFC;
        tick;
        pcen = 0;
        chk("t5_pcplus4_wrap", pcplus4, 0);
        pcen = 1; pcnext = 32'h100; fetch_start = 1;
        tick;
        pcen = 0; fetch_start = 0;
        chk("t5_old_pc_addr", imem.mem_addr, 32'hFFFF_FFFC);
        chk("t5_new_pc", pc, 32'h100);
        imem.mem_ready = 1; imem.mem_rdata = 32'h0000_0008;
        tick;
        imem.mem_ready = 0;
        tick;

        fetch_start = 1; imem.mem_rdata = 32'hDEAD_BEEF;
        tick;
        fetch_start = 0;
        #2 reset = 0;
        #1;
        chk("t6_req", imem.mem_req, 0);
        chk("t6_pc", pc, RESET_PC);
        chk("t6_ir", ir, 0);
        chk("t6_addr", imem.mem_addr, 0);
        chk("t6_busy", busy, 0);
        tick;
        reset = 1;
        imem.mem_ready = 1;
        tick;
        imem.mem_ready = 0;
        chk("t6_late_ir", ir, 0);
        chk("t6_late_valid", instr_valid, 0);
        chk("t6_late_busy", busy, 0);
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Upstream front end of the multicycle MIPS core. It owns the PC and instruction register and runs a request/ready fetch handshake to instruction memory. It feeds op/funct (plus register and immediate fields) to the multicycle controller.
- Controller requests a fetch in its FETCH state and waits for instr_valid before advancing.
- The unit tolerates variable-latency memory, flags misaligned or timed-out fetches, and updates the PC on controller command.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before fault
TW, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
fetch_start  in  1  controller request to fetch instruction at current pc
pcen  in  1  controller PC write enable
pcnext  in  32  next PC from datapath (pc+4/branch/jump mux)
fault_clr  in  1  clears sticky fault, returns to IDLE
mem_req  out  1  instruction memory read request
mem_addr  out  32  fetch byte address (held stable while mem_req=1)
mem_rdata  in  32  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion strobe
instr_valid  out  1  one-cycle pulse: ir just loaded
busy  out  1  high in REQ or DONE
fault  out  1  sticky: misaligned fetch or timeout
fault_code  out  2  00 none, 01 misaligned, 10 timeout
pc  out  32  current PC
pcplus4  out  32  pc + 4, combinational, wraps mod 2^32
ir  out  32  instruction register
op  out  6  ir[31:26]
funct  out  6  ir[5:0]
rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11]
imm  out  16  ir[15:0]

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, ir=0, mem_req=0, mem_addr=0, instr_valid=0, fault=0, fault_code=00, timeout counter=0. All outputs take these values immediately on assertion, including mid-fetch; any in-flight mem_ready is discarded.
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE, fetch_start=1, pc[1:0]==0: latch fetch_addr=pc, go to REQ. mem_req=1 and mem_addr=fetch_addr from the next cycle.
- IDLE, fetch_start=1, pc[1:0]!=0: go to FAULT with fault_code=01. No mem_req is issued.
- REQ, mem_ready=1: ir<=mem_rdata, go to DONE, mem_req drops the next cycle. Minimum latency is fetch_start to instr_valid = 2 cycles when memory is ready in the first REQ cycle.
- REQ, mem_ready=0: counter increments. When the counter reaches TIMEOUT-1 with no ready, go to FAULT with fault_code=10 and drop mem_req. A ready arriving on that same cycle wins: the fetch completes and no fault is raised.
- DONE: instr_valid=1 for exactly one cycle, then IDLE. A fetch_start in DONE is ignored.
- FAULT: fault=1, busy=0. Holds until fault_clr=1, which returns the unit to IDLE with fault_code=00 next cycle. fetch_start in FAULT is ignored.
- fetch_start in REQ/DONE: ignored, no queueing.
- mem_ready while mem_req=0: ignored.
- pcen=1: pc<=pcnext in any state. mem_addr in flight is unaffected because fetch_addr is latched. pcen and fetch_start on the same cycle: fetch uses the old pc.
- ir changes only on a completed fetch. Decoded fields are pure slices of ir and are stable between fetches.

Decomposition:
- Shared package mips_pkg holds the fetch FSM state enum (IDLE/REQ/DONE/FAULT), fault code constants (FC_NONE, FC_MISALIGN, FC_TIMEOUT), and opcode field position constants shared with the controller.
- One natural sub-module: mips_ir_decode, a combinational field split of ir into op/funct/rs/rt/rd/imm, reusable by the controller bench.

Test Plan:
- Reset then fetch_start with memory ready in the same cycle, mem_rdata=32'h20020005 -> mem_addr=0, instr_valid 2 cycles after start, op=6'b001000, rt=2, imm=5, mem_req high exactly 1 cycle.
- Memory with 3-cycle latency returning 32'h00853020 -> mem_req high 3 cycles with mem_addr stable, then op=0, funct=6'b100000, rs=4, rt=5, rd=6.
- pcen=1 with pcnext=32'h0000_0006, then fetch_start -> FAULT, fault_code=01, mem_req never asserted. fault_clr -> IDLE, fault=0.
- Memory never ready with TIMEOUT=16 -> fault=1, fault_code=10 exactly 16 cycles after mem_req rises. Repeat with ready on cycle 16 -> no fault, ir loaded.
- pcen with pcnext=32'h40 asserted mid-REQ -> mem_addr stays at old pc, pc=32'h40 afterwards, pcplus4=32'h44. pcnext=32'hFFFF_FFFC -> pcplus4=0.
- Drive reset low during REQ -> mem_req=0, pc=RESET_PC, ir=0 immediately. A late mem_ready after release has no effect.
